// File: rtl/uart_pkg.sv
// uart_pkg: types, constants and helpers shared by the UART transmitter
// and the bridge's UART receiver (frame format and baud arithmetic).
package uart_pkg;

    // Frame sequencer states. PARITY is only visited in 8E1 builds.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int DATA_BITS = 8;

    // Clocks per serial bit (integer divide, truncating).
    function automatic int baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Even parity: the returned bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: reloadable down-counter that times one serial bit.
// bit_done pulses for the single clock in which the count sits at zero
// while enabled; the counter then reloads itself so bit periods chain
// without a gap. Shared with the receiver.
module uart_baud_tick #(
    parameter int BAUD_DIV = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic bit_done
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_r;

    // Down-count while enabled; explicit load or terminal count reloads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= RELOAD;
        end else if (en) begin
            if (cnt_r == CNT_ZERO) begin
                cnt_r <= RELOAD;
            end else begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bit_done = en && (cnt_r == CNT_ZERO);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, valid/ready byte input, one frame in flight,
// LSB first, line idles high. Default frame is 8N1.
// Build option: define UART_TX_PARITY_EN to insert an even parity bit
// after the data bits (8E1 frame).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic [2:0]           state_r;
    logic [2:0]           state_s;
    logic [DATA_BITS-1:0] shift_reg_r;
    logic [DATA_BITS-1:0] shift_reg_s;
    logic [2:0]           bit_cnt_r;
    logic [2:0]           bit_cnt_s;
    logic                 tx_r;
    logic                 tx_s;
    logic                 tx_ready_r;
    logic                 tx_busy_r;
    logic                 accept_s;
    logic                 bit_done_s;
    logic                 in_frame_s;

    // Handshake is only possible from IDLE; bytes offered while busy are dropped.
    assign accept_s   = tx_valid && (state_r == ST_IDLE);
    assign in_frame_s = (state_r != ST_IDLE);

    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .load     (accept_s),
        .en       (in_frame_s),
        .bit_done (bit_done_s)
    );

    // Frame sequencer: next state, next line level and data-bit pointer.
    always_comb begin
        state_s     = state_r;
        shift_reg_s = shift_reg_r;
        bit_cnt_s   = bit_cnt_r;
        tx_s        = tx_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_s     = ST_START;
                    shift_reg_s = tx_data;
                    bit_cnt_s   = 3'd0;
                    tx_s        = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                    tx_s    = 1'b1;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_s   = ST_DATA;
                    bit_cnt_s = 3'd0;
                    tx_s      = shift_reg_r[0];
                end else begin
                    tx_s = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    if (bit_cnt_r == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_s = ST_PARITY;
                        tx_s    = even_parity(shift_reg_r);
`else
                        state_s = ST_STOP;
                        tx_s    = 1'b1;
`endif
                    end else begin
                        bit_cnt_s = bit_cnt_r + 3'd1;
                        tx_s      = shift_reg_r[bit_cnt_r + 3'd1];
                    end
                end else begin
                    tx_s = shift_reg_r[bit_cnt_r];
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_s = ST_STOP;
                    tx_s    = 1'b1;
                end else begin
                    tx_s = even_parity(shift_reg_r);
                end
            end
`endif
            ST_STOP: begin
                if (bit_done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
                tx_s = 1'b1;
            end
            default: begin
                // Unused encodings fall back to an idle, high line.
                state_s   = ST_IDLE;
                bit_cnt_s = 3'd0;
                tx_s      = 1'b1;
            end
        endcase
    end

    // State and output registers; ready/busy are registered decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shift_reg_r <= {DATA_BITS{1'b0}};
            bit_cnt_r   <= 3'd0;
            tx_r        <= 1'b1;
            tx_ready_r  <= 1'b1;
            tx_busy_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            shift_reg_r <= shift_reg_s;
            bit_cnt_r   <= bit_cnt_s;
            tx_r        <= tx_s;
            tx_ready_r  <= (state_s == ST_IDLE);
            tx_busy_r   <= (state_s != ST_IDLE);
        end
    end

    assign tx       = tx_r;
    assign tx_ready = tx_ready_r;
    assign tx_busy  = tx_busy_r;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized/directed stimulus with a scoreboard. Sent bytes
// are queued as expected frames; an independent line monitor decodes the
// serial waveform and compares each frame against the reference frame.
module tb_uart_tx;

    localparam int CLK_FREQ   = 1600;
    localparam int BAUD_RATE  = 100;
    localparam int BAUD_DIV   = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CLKS = FRAME_BITS * BAUD_DIV;
    localparam int WAIT_MAX   = 4 * FRAME_CLKS;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    int         hs_cycles[$];
    int         cycle = 0;
    int         frames_seen = 0;
    int         frames_sent = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference frame, bit 0 first on the line: start 0, data LSB first,
    // optional even parity, stop 1. Unused upper positions read as 1.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic [10:0] f;
        f = 11'h7FF;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[9]  = ($countones(d) % 2 == 1) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
`else
        f[9]  = 1'b1;
`endif
        return f;
    endfunction

    // Log the cycle number of every accepted handshake.
    always @(posedge clk) begin
        if (rst == 1'b0 && tx_valid && tx_ready) hs_cycles.push_back(cycle);
        cycle <= cycle + 1;
    end

    // Line monitor: capture a full frame from the first low sample, check
    // each bit is flat for its whole period, and score it.
    initial begin : monitor
        logic [10:0] got;
        logic        stable;
        logic        aborted;
        logic [7:0]  exp_b;
        forever begin
            @(negedge clk);
            if (rst !== 1'b0 || tx !== 1'b0) continue;
            got     = 11'h7FF;
            stable  = 1'b1;
            aborted = 1'b0;
            for (int b = 0; b < FRAME_BITS; b++) begin
                for (int c = 0; c < BAUD_DIV; c++) begin
                    if (b != 0 || c != 0) @(negedge clk);
                    if (rst !== 1'b0) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (c == 0) got[b] = tx;
                    else if (tx !== got[b]) stable = 1'b0;
                end
                if (aborted) break;
            end
            if (!aborted) begin
                frames_seen++;
                check("bit_stable", 32'(stable), 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame: got 0x%0h, expected no frame", got);
                end else begin
                    exp_b = exp_q.pop_front();
                    check("frame", 32'(got), 32'(ref_frame(exp_b)));
                end
            end
        end
    end

    // Wait (bounded) for ready, present a byte, return one negedge after the handshake.
    task automatic send(input logic [7:0] d, input bit hold);
        int t;
        t = 0;
        while (tx_ready !== 1'b1 && t < WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        if (tx_ready !== 1'b1) begin
            n_checks++;
            n_errors++;
            $display("FAIL ready_timeout: got tx_ready=%0b, expected 1", tx_ready);
            return;
        end
        tx_data  = d;
        tx_valid = 1'b1;
        exp_q.push_back(d);
        frames_sent++;
        @(negedge clk);
        if (!hold) tx_valid = 1'b0;
    endtask

    // Count negedges with tx_ready low; also note any busy/ready disagreement.
    task automatic measure_busy(output int n, output int bad);
        n   = 0;
        bad = 0;
        while (tx_ready === 1'b0 && n < WAIT_MAX) begin
            if (tx_busy !== 1'b1) bad++;
            n++;
            @(negedge clk);
        end
    endtask

    initial begin : stimulus
        int n;
        int bad;
        int h0;
        int t;
        logic [7:0] d;
        logic [7:0] fixed[4];

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_ready", 32'(tx_ready), 32'd1);
        check("reset_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single frame, full-length busy window.
        send(8'hA5, 1'b0);
        check("tx_fall", 32'(tx), 32'd0);
        check("ready_low_after_hs", 32'(tx_ready), 32'd0);
        measure_busy(n, bad);
        check("ready_low_clks", 32'(n), 32'(FRAME_CLKS));
        check("busy_vs_ready", 32'(bad), 32'd0);
        check("ready_back_high", 32'(tx_ready), 32'd1);
        repeat (5) @(negedge clk);

        // Back-to-back with tx_valid held high.
        h0 = hs_cycles.size();
        send(8'h00, 1'b1);
        tx_data = 8'hFF;
        exp_q.push_back(8'hFF);
        frames_sent++;
        t = 0;
        while (hs_cycles.size() < h0 + 2 && t < WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        tx_valid = 1'b0;
        check("b2b_handshakes", 32'(hs_cycles.size() - h0), 32'd2);
        if (hs_cycles.size() >= h0 + 2)
            check("b2b_spacing", 32'(hs_cycles[h0 + 1] - hs_cycles[h0]), 32'(FRAME_CLKS + 1));

        // Offer a byte mid-frame: it must be dropped.
        h0 = hs_cycles.size();
        send(8'h96, 1'b0);
        repeat (40) @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (FRAME_CLKS) @(negedge clk);
        check("busy_offer_ignored", 32'(hs_cycles.size() - h0), 32'd1);
        check("no_pending_after_ignore", 32'(exp_q.size()), 32'd0);

        // Reset fifty clocks into a frame.
        send(8'hC3, 1'b0);
        repeat (49) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_tx", 32'(tx), 32'd1);
        check("midreset_ready", 32'(tx_ready), 32'd1);
        check("midreset_busy", 32'(tx_busy), 32'd0);
        void'(exp_q.pop_back());
        frames_sent--;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'h81, 1'b0);

        // Fixed patterns, then random bytes with random idle gaps.
        fixed[0] = 8'h00;
        fixed[1] = 8'h55;
        fixed[2] = 8'hAA;
        fixed[3] = 8'hFF;
        for (int i = 0; i < 4; i++) send(fixed[i], 1'b0);
        send(8'h07, 1'b0);
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom_range(0, 255));
            send(d, 1'b0);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end

        // Drain.
        t = 0;
        while (exp_q.size() != 0 && t < WAIT_MAX) begin
            @(negedge clk);
            t++;
        end
        repeat (BAUD_DIV) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("frame_count", 32'(frames_seen), 32'(frames_sent));
        check("final_idle_tx", 32'(tx), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
